// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : MIPS instruction-fetch stage with req/ack memory handshake, stall
//            hold buffer and flush drain. Optional macro IF_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_keep,
    input  logic        flush,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_id_misalign
`endif
);

    localparam logic [31:0] c_pc_step = 32'd4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_pending, w_pending_nxt;
    logic [31:0] r_req_addr;
    logic [31:0] r_hold_instr, r_hold_pc;
    logic        r_valid;
    logic [31:0] r_instr, r_pc, r_pc4;

    logic        w_slot_free;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_keep;
    logic        w_load;
    logic [31:0] w_load_instr, w_load_pc;
    logic        w_capture;
    logic        w_latch_addr;
`ifdef IF_ALIGN_CHECK_EN
    logic        r_misalign;
    logic        w_inject;
`endif

    assign w_slot_free = !r_valid || !id_stall;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = 1'b0;
        w_req         = 1'b0;
        w_addr        = pc;
        w_keep        = 1'b1;
        w_load        = 1'b0;
        w_load_instr  = imem_rdata;
        w_load_pc     = pc;
        w_capture     = 1'b0;
        w_latch_addr  = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        w_inject      = 1'b0;
`endif
        case (r_state)
            S_REQ: begin
`ifdef IF_ALIGN_CHECK_EN
                if (pc[1:0] != 2'b00) begin
                    // Misaligned PC never reaches memory; a NOP stands in for it
                    if (flush) begin
                        w_keep = 1'b0;
                    end else if (w_slot_free) begin
                        w_inject     = 1'b1;
                        w_load       = 1'b1;
                        w_load_instr = NOP_INSTR;
                        w_keep       = 1'b0;
                    end
                end else
`endif
                begin
                    // An issued request stays up until acked, even if decode stalls
                    w_req        = w_slot_free || r_pending;
                    w_latch_addr = w_req;
                    if (flush) begin
                        w_keep = 1'b0;
                        if (w_req && !imem_ack) begin
                            w_state_nxt = S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (w_slot_free) begin
                            w_load = 1'b1;
                            w_keep = 1'b0;
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        w_pending_nxt = w_req;
                    end
                end
            end
            S_HOLD: begin
                w_keep = !w_slot_free;
                if (flush) begin
                    w_keep      = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_load_pc    = r_hold_pc;
                    w_state_nxt  = S_REQ;
                end
            end
            S_DRAIN: begin
                // Finish the stale transaction; its data is thrown away
                w_req  = 1'b1;
                w_addr = r_req_addr;
                w_keep = !flush;
                if (imem_ack && !flush) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pending    <= 1'b0;
            r_req_addr   <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc         <= 32'd0;
            r_pc4        <= 32'd0;
`ifdef IF_ALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_latch_addr) begin
                r_req_addr <= pc;
            end
            if (w_capture) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= pc;
            end
            if (flush) begin
                r_valid    <= 1'b0;
                r_instr    <= NOP_INSTR;
`ifdef IF_ALIGN_CHECK_EN
                r_misalign <= 1'b0;
`endif
            end else if (w_load) begin
                r_valid    <= 1'b1;
                r_instr    <= w_load_instr;
                r_pc       <= w_load_pc;
                r_pc4      <= w_load_pc + c_pc_step;
`ifdef IF_ALIGN_CHECK_EN
                r_misalign <= w_inject;
`endif
            end else if (w_slot_free) begin
                r_valid    <= 1'b0;
                r_instr    <= NOP_INSTR;
`ifdef IF_ALIGN_CHECK_EN
                r_misalign <= 1'b0;
`endif
            end
        end
    end

    assign pc_keep     = w_keep;
    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign if_id_valid = r_valid;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_pc;
    assign if_id_pc4   = r_pc4;
`ifdef IF_ALIGN_CHECK_EN
    assign if_id_misalign = r_misalign;
`endif

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. Sits directly downstream of the PC register.
- Consumes the current `pc` and issues a request to instruction memory over a variable-latency req/ack handshake.
- Buffers a response that arrives while decode is stalled, and loads the IF/ID pipeline register.
- Drives the PC register's `keep` input so the PC advances only when the fetched instruction has been consumed. On flush, it drops any in-flight fetch.

Parameters:
- NOP_INSTR, 32'h0000_0000: value driven on `if_id_instr` when the slot is empty or after reset/flush (sll $0,$0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- pc  input  32  current PC from the PC register
- pc_keep  output  1  to the PC register's `keep`; 1 = hold PC, 0 = load next/target
- flush  input  1  redirect (jump/branch taken this cycle); PC register loads target when pc_keep=0
- id_stall  input  1  decode cannot accept a new instruction this cycle
- imem_req  output  1  fetch request; held high with stable imem_addr until imem_ack
- imem_addr  output  32  fetch address
- imem_ack  input  1  response valid; may assert in the same cycle as imem_req (zero-wait)
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- if_id_valid  output  1  IF/ID register holds a live instruction
- if_id_instr  output  32  IF/ID instruction
- if_id_pc  output  32  PC of the IF/ID instruction
- if_id_pc4  output  32  if_id_pc + 4, modulo 2^32

Behaviour:
- Slot free: slot_free = !if_id_valid || !id_stall.
- FSM states: REQ, HOLD, DRAIN. Reset state is REQ.
- Reset values:
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0.
  - Hold buffer and req_addr cleared.
  - A request abandoned by reset is not tracked; instruction memory shares `rst`.
- IF/ID register load: when id_stall=0, the IF/ID register takes the new entry, or goes invalid with NOP_INSTR if there is none. When id_stall=1 and if_id_valid=1, the IF/ID register holds.
- REQ state:
  - imem_req = slot_free; imem_addr = pc; req_addr latches pc every cycle imem_req=1.
  - On imem_ack & slot_free, with no flush: {imem_rdata, pc, pc+4} goes into IF/ID the next cycle; pc_keep=0; stay in REQ. Latency is 1 cycle from ack to if_id_valid, so throughput is 1 instruction/cycle with zero-wait memory.
  - Otherwise pc_keep=1.
  - Once imem_req rises it stays high until ack, even if id_stall rises. If ack arrives while the slot is not free: capture into the hold buffer, pc_keep=1, go to HOLD.
- HOLD state:
  - imem_req=0; pc_keep = !slot_free.
  - When slot_free: the buffer moves into IF/ID; pc_keep=0 that cycle; go to REQ.
- DRAIN state:
  - imem_req=1; imem_addr=req_addr (the stale request).
  - pc_keep=1, except under flush, where it is 0.
  - On imem_ack: discard the data and go to REQ.
- Flush has priority over all other events:
  - pc_keep=0 that cycle.
  - if_id_valid=0 and if_id_instr=NOP_INSTR next cycle.
  - Hold buffer dropped.
  - REQ with imem_req=1 and no ack: go to DRAIN. REQ with ack in the same cycle: data discarded, stay in REQ.
  - HOLD: go to REQ.
  - DRAIN: stay in DRAIN.
- Flush combined with id_stall: flush wins; IF/ID is invalidated regardless.
- PC wrap-around: if_id_pc4 of 32'hFFFF_FFFC is 32'h0000_0000.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- When defined:
  - Adds output `if_id_misalign` (1 bit).
  - In REQ, if pc[1:0]!=0, no memory request is issued (imem_req=0). The stage injects {NOP_INSTR, pc, pc+4} with if_id_misalign=1 when slot_free, with pc_keep=0 that cycle.
  - if_id_misalign resets to 0 and clears on flush and on every normal load.
- When undefined: no port, no check; pc[1:0] passes to imem_addr unchanged.

Test Plan:
- Reset then zero-wait memory (ack same cycle), pc 0,4,8 → if_id_pc = 0,4,8 on consecutive cycles; if_id_pc4 = 4,8,12; pc_keep=0 each fetch cycle.
- 3-cycle memory latency at pc=0x100 → imem_req high with imem_addr=0x100 for 3 cycles; pc_keep=1 for 2 cycles then 0 on the ack cycle; if_id_instr = rdata next cycle.
- IF/ID valid, id_stall=1, ack arrives for pc=0x20 → enter HOLD with pc_keep=1. id_stall drops → IF/ID = {rdata, 0x20}; pc_keep=0 that cycle.
- Request for pc=0x40 outstanding, flush with target 0x80 → if_id_valid=0 next cycle. Stay in DRAIN with imem_addr=0x40 until ack; that data is never loaded. The next request uses imem_addr=0x80.
- rst pulse during HOLD → next cycle if_id_valid=0, if_id_instr=NOP_INSTR, state REQ.
- IF_ALIGN_CHECK_EN defined, pc=0x102 → imem_req=0; if_id_misalign=1 with if_id_pc=0x102 next cycle.
